memshare_rqst_sched: RTL
========================

Name: memshare_rqst_sched

Overview:
Multi-cycle scheduler for shared group 2, the partially-parallelised column banks. It takes the per-requestor share request flags produced by the access request generator and serialises the flagged requestors onto PORT_NUM shared bank ports. Each round grants at most PORT_NUM requestors, lowest index first, under a valid/ready handshake. When all flagged requestors are served, it reports completion and the number of rounds used. It sits between the access request generator and the shared column-bank/IB-LUT read mux in the layered decoder.

Parameters:
SHARED_BANK_NUM, 5, number of requestors in the share group (GP1+GP2)
PORT_NUM, 2, number of shared-bank ports available per cycle (1..SHARED_BANK_NUM)
PORT_SEL_BITWIDTH, 1, width of one port index; equals max(1, clog2(PORT_NUM))
ROUND_BITWIDTH, 3, width of the round counter; equals clog2(SHARED_BANK_NUM+1)

Ports:
sys_clk  input  1  system clock
rstn  input  1  synchronous active-low reset
rqst_valid_i  input  1  one-cycle strobe; rqst_flag_i is valid in this cycle
rqst_flag_i  input  SHARED_BANK_NUM  share request flags from the access request generator; bit i=1 means requestor i needs a shared port
grant_ready_i  input  1  downstream port mux accepts the current grant
grant_valid_o  output  1  grant_o/port_sel_o are valid
grant_o  output  SHARED_BANK_NUM  one-hot-per-requestor grant mask for this round
port_sel_o  output  SHARED_BANK_NUM*PORT_SEL_BITWIDTH  per-requestor port index; field i is at bits [(i+1)*W-1:i*W]
busy_o  output  1  scheduler is not in IDLE
done_o  output  1  one-cycle completion pulse
round_cnt_o  output  ROUND_BITWIDTH  number of rounds issued in the last job; valid while done_o=1 and held until the next accepted job

Behaviour:
- Clocking/reset: single clock sys_clk; reset rstn is synchronous and active-low.
- Reset values: all outputs are 0 (grant_valid_o, grant_o, port_sel_o, busy_o, done_o, round_cnt_o); state=IDLE; the internal pending mask is 0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, rqst_valid_i=1:
  - pending <= rqst_flag_i; round counter <= 0.
  - If rqst_flag_i is 0, go to DONE; otherwise go to ISSUE.
  - rqst_valid_i outside IDLE is ignored; no queueing.
- ISSUE:
  - grant_valid_o=1; grant_o = the lowest min(PORT_NUM, popcount(pending)) set bits of pending.
  - port_sel_o gives the k-th granted requestor (k counted from LSB) port index k. Fields of non-granted requestors are 0.
  - The first grant appears the cycle after rqst_valid_i.
  - Handshake: when grant_ready_i=1, the grant is consumed: pending &= ~grant_o and the round counter increments. The next grant, if any, is presented in the following cycle, so back-to-back rounds are possible.
  - When grant_ready_i=0, grant_o, port_sel_o and grant_valid_o hold stable and pending does not change.
  - When the consumed grant empties pending, the next state is DONE and grant_valid_o deasserts in that cycle.
- DONE: done_o=1 and round_cnt_o = number of rounds consumed, which is ceil(popcount(flags)/PORT_NUM). Return to IDLE in the next cycle.
- busy_o=1 in ISSUE and in DONE.
- Timing: a job with R rounds and no backpressure has done_o at t+R+1 (t is the rqst_valid_i cycle). A zero-flag job has done_o at t+1 with round_cnt_o=0.
- rstn low in any state returns to IDLE on the next edge, drops any outstanding grant without consuming it, and clears round_cnt_o.
- Arithmetic: the round counter saturates at SHARED_BANK_NUM, which is never exceeded since each round clears at least one bit.

Decomposition:
- Shared package holds: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DONE=2'd2) and the PORT_SEL_BITWIDTH / ROUND_BITWIDTH derivation functions (clog2).
- One sub-module: lowk_select.
  - Purely combinational.
  - Given a SHARED_BANK_NUM-bit mask, it outputs the mask of its lowest PORT_NUM set bits and the per-bit port index, using a prefix popcount.
  - The top level holds the FSM, the pending register, the counter and the output registers.

Test Plan:
- Flags 5'b10110, PORT_NUM=2, ready=1 at t → t+1: grant_o=00110, port_sel req1=0 and req2=1. t+2: grant_o=10000, req4 sel=0. t+3: done_o=1, round_cnt_o=2. t+4: busy_o=0.
- Flags 5'b11111 → grants 00011, 01100, 10000 on consecutive cycles, then done_o=1 with round_cnt_o=3.
- Flags 5'b00000 → grant_valid_o never asserts; done_o=1 at t+1, round_cnt_o=0.
- Flags 5'b01001, grant_ready_i=0 for t+1..t+2 → grant_o=01001 held stable for 3 cycles, consumed at t+3; done_o at t+4 with round_cnt_o=1.
- A second rqst_valid_i with flags 5'b00001 during ISSUE → ignored; after done_o, pending was never altered (no grant to req0 unless it was in the original job).
- rstn=0 at t+2 of the 5'b11111 job → next cycle all outputs are 0 and state is IDLE; a new job with 5'b00100 then completes in 1 round.

Source files
------------

// File: rtl/memshare_rqst_sched_pkg.sv
// Shared definitions for the share-group-2 request scheduler: FSM encoding
// and the width derivations for port indices and the round counter.
package memshare_rqst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // A port index needs at least one bit even when only one port exists.
  function automatic int port_sel_w(input int port_num);
    return (clog2(port_num) < 1) ? 1 : clog2(port_num);
  endfunction

  // Round counter must hold 0..bank_num.
  function automatic int round_w(input int bank_num);
    return clog2(bank_num + 1);
  endfunction

endpackage

// File: rtl/memshare_rqst_sched_if.sv
// Request/grant bundle between the access request generator, the scheduler
// and the shared column-bank / IB-LUT read mux.
interface memshare_rqst_sched_if #(
  parameter int SHARED_BANK_NUM   = 5,
  parameter int PORT_SEL_BITWIDTH = 1,
  parameter int ROUND_BITWIDTH    = 3
);

  logic                                        rqst_valid_i;
  logic [SHARED_BANK_NUM-1:0]                  rqst_flag_i;
  logic                                        grant_ready_i;
  logic                                        grant_valid_o;
  logic [SHARED_BANK_NUM-1:0]                  grant_o;
  logic [SHARED_BANK_NUM*PORT_SEL_BITWIDTH-1:0] port_sel_o;
  logic                                        busy_o;
  logic                                        done_o;
  logic [ROUND_BITWIDTH-1:0]                   round_cnt_o;

  // Requestor / downstream side.
  modport master (
    output rqst_valid_i, rqst_flag_i, grant_ready_i,
    input  grant_valid_o, grant_o, port_sel_o, busy_o, done_o, round_cnt_o
  );

  // Scheduler side.
  modport slave (
    input  rqst_valid_i, rqst_flag_i, grant_ready_i,
    output grant_valid_o, grant_o, port_sel_o, busy_o, done_o, round_cnt_o
  );

endinterface

// File: rtl/memshare_rqst_sched_lowk_select.sv
// Picks the lowest PORT_NUM set bits of a mask and tags each picked bit with
// its rank (port index) using a running prefix popcount. Purely combinational.
module memshare_rqst_sched_lowk_select #(
  parameter int SHARED_BANK_NUM   = 5,
  parameter int PORT_NUM          = 2,
  parameter int PORT_SEL_BITWIDTH = 1
) (
  input  logic [SHARED_BANK_NUM-1:0]                   mask,
  output logic [SHARED_BANK_NUM-1:0]                   sel_mask,
  output logic [SHARED_BANK_NUM*PORT_SEL_BITWIDTH-1:0] port_idx
);

  // Walk from LSB, counting set bits seen so far; a set bit is selected while
  // fewer than PORT_NUM bits precede it, and that count is its port index.
  always_comb begin
    int cnt;
    cnt      = 0;
    sel_mask = '0;
    port_idx = '0;
    for (int i = 0; i < SHARED_BANK_NUM; i++) begin
      if (mask[i]) begin
        if (cnt < PORT_NUM) begin
          sel_mask[i] = 1'b1;
          port_idx[i*PORT_SEL_BITWIDTH +: PORT_SEL_BITWIDTH] = PORT_SEL_BITWIDTH'(cnt);
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/memshare_rqst_sched.sv
// Multi-cycle scheduler serialising flagged share-group-2 requestors onto
// PORT_NUM shared bank ports, lowest index first, one round per accepted
// grant. All outputs are registered; the next grant is computed from the
// next pending mask so a consumed round is followed immediately by the next.
module memshare_rqst_sched
  import memshare_rqst_sched_pkg::*;
#(
  parameter int SHARED_BANK_NUM   = 5,
  parameter int PORT_NUM          = 2,
  parameter int PORT_SEL_BITWIDTH = port_sel_w(PORT_NUM),
  parameter int ROUND_BITWIDTH    = round_w(SHARED_BANK_NUM)
) (
  input logic                  sys_clk,
  input logic                  rstn,
  memshare_rqst_sched_if.slave bus
);

  localparam int PS_W = SHARED_BANK_NUM * PORT_SEL_BITWIDTH;

  state_t                      state_q, state_nxt;
  logic [SHARED_BANK_NUM-1:0]  pending_q, pending_nxt;
  logic [ROUND_BITWIDTH-1:0]   round_q, round_nxt;
  logic                        accept;

  logic                        grant_valid_q;
  logic [SHARED_BANK_NUM-1:0]  grant_q;
  logic [PS_W-1:0]             port_sel_q;
  logic                        busy_q;
  logic                        done_q;
  logic [ROUND_BITWIDTH-1:0]   round_cnt_q;

  logic [SHARED_BANK_NUM-1:0]  sel_mask;
  logic [PS_W-1:0]             sel_idx;

  memshare_rqst_sched_lowk_select #(
    .SHARED_BANK_NUM   (SHARED_BANK_NUM),
    .PORT_NUM          (PORT_NUM),
    .PORT_SEL_BITWIDTH (PORT_SEL_BITWIDTH)
  ) u_lowk_select (
    .mask     (pending_nxt),
    .sel_mask (sel_mask),
    .port_idx (sel_idx)
  );

  // Next-state, next pending mask and next round count.
  always_comb begin
    state_nxt   = state_q;
    pending_nxt = pending_q;
    round_nxt   = round_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rqst_valid_i) begin
          accept      = 1'b1;
          pending_nxt = bus.rqst_flag_i;
          round_nxt   = '0;
          state_nxt   = (bus.rqst_flag_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (grant_valid_q && bus.grant_ready_i) begin
          pending_nxt = pending_q & ~grant_q;
          // Saturate; each round clears at least one bit so this never binds.
          round_nxt   = (round_q == ROUND_BITWIDTH'(SHARED_BANK_NUM)) ?
                        round_q : round_q + 1'b1;
          if ((pending_q & ~grant_q) == '0) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pending mask, counter and all output registers.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      round_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      port_sel_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      round_cnt_q   <= '0;
    end else begin
      state_q       <= state_nxt;
      pending_q     <= pending_nxt;
      round_q       <= round_nxt;
      grant_valid_q <= (state_nxt == ISSUE);
      grant_q       <= (state_nxt == ISSUE) ? sel_mask : '0;
      port_sel_q    <= (state_nxt == ISSUE) ? sel_idx  : '0;
      busy_q        <= (state_nxt != IDLE);
      done_q        <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        round_cnt_q <= round_nxt;
      end else if (accept) begin
        round_cnt_q <= '0;
      end
    end
  end

  assign bus.grant_valid_o = grant_valid_q;
  assign bus.grant_o       = grant_q;
  assign bus.port_sel_o    = port_sel_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.round_cnt_o   = round_cnt_q;

endmodule
